// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11 console serial-line responder: register
// offsets, CSR bit positions, base address and register word formatting.
package dl11_pkg;

    typedef enum logic [1:0] {
        REG_RCSR = 2'd0,
        REG_RBUF = 2'd1,
        REG_XCSR = 2'd2,
        REG_XBUF = 2'd3
    } dl11_reg_e;

    localparam int BIT_DONE  = 7;
    localparam int BIT_RDY   = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_MAINT = 2;
    localparam int BIT_OVR   = 14;
    localparam int BIT_ERR   = 15;

    localparam logic [21:0] DL11_BASE_ADDR = 22'o17777560;

    function automatic logic [15:0] csr_word(input logic flag, input logic ie, input logic maint);
        logic [15:0] w;
        w            = '0;
        w[BIT_DONE]  = flag;
        w[BIT_IE]    = ie;
        w[BIT_MAINT] = maint;
        return w;
    endfunction

    function automatic logic [15:0] rbuf_word(input logic ovr, input logic [7:0] data);
        logic [15:0] w;
        w          = {8'h00, data};
        w[BIT_ERR] = ovr;
        w[BIT_OVR] = ovr;
        return w;
    endfunction

endpackage

// File: rtl/dl11_rxfifo.sv
// Synchronous receive FIFO for the DL11 RX path; head is visible combinationally.
// Caller must not push when full unless it pops in the same cycle.
module dl11_rxfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dl11_uart.sv
// DL11-style console responder: RCSR/RBUF/XCSR/XBUF on the uart req/ack port,
// byte-stream RX/TX bridge and level IRQs. Define DL11_RXFIFO_EN for a FIFO RX path.
module dl11_uart
    import dl11_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uartreq,
    input  logic [2:0]  uartaddr,
    input  logic        uartwr,
    input  logic [15:0] uartwdata,
    output logic        uartack,
    output logic [15:0] uartrdata,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        rx_irq,
    output logic        tx_irq
);
    dl11_reg_e   reg_sel;
    logic        wr_rcsr, wr_xcsr, wr_xbuf, rd_rbuf;
    logic        ack_q;
    logic [15:0] rdata_q, rdata_d;
    logic        rie_q, xie_q, maint_q;
    logic        rdy_q, rdy_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        lb_valid_q, lb_valid_d;
    logic [7:0]  lb_data_q, lb_data_d;
    logic        ovr_q, ovr_d;
    logic        rx_irq_q, tx_irq_q;
    logic        rx_done;
    logic [7:0]  rx_byte;
    logic        rx_push;
    logic [7:0]  rx_push_data;
    logic        tx_hs;
    logic        unused_bits;

    assign reg_sel = dl11_reg_e'(uartaddr[2:1]);
    assign wr_rcsr = uartreq &  uartwr & (reg_sel == REG_RCSR);
    assign wr_xcsr = uartreq &  uartwr & (reg_sel == REG_XCSR);
    assign wr_xbuf = uartreq &  uartwr & (reg_sel == REG_XBUF);
    assign rd_rbuf = uartreq & ~uartwr & (reg_sel == REG_RBUF);

    assign unused_bits = ^{uartaddr[0], uartwdata[15:8]};

    // In maintenance mode the serializer is cut off and XBUF loops into RX.
    assign tx_hs        = tx_valid_q & ~maint_q & tx_ready;
    assign rx_push      = maint_q ? lb_valid_q : rx_valid;
    assign rx_push_data = maint_q ? lb_data_q  : rx_data;

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rdy_d      = rdy_q;
        lb_valid_d = 1'b0;
        lb_data_d  = lb_data_q;
        if (tx_hs)      begin tx_valid_d = 1'b0; rdy_d = 1'b1; end
        if (lb_valid_q) rdy_d = 1'b1;
        if (wr_xbuf) begin
            tx_data_d = uartwdata[7:0];
            rdy_d     = 1'b0;
            if (maint_q) begin
                lb_valid_d = 1'b1;
                lb_data_d  = uartwdata[7:0];
            end else begin
                tx_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (uartreq && !uartwr) begin
            case (reg_sel)
                REG_RCSR: rdata_d = csr_word(rx_done, rie_q, 1'b0);
                REG_RBUF: rdata_d = rbuf_word(ovr_q, rx_byte);
                REG_XCSR: rdata_d = csr_word(rdy_q, xie_q, maint_q);
                default:  rdata_d = '0;
            endcase
        end
    end

`ifdef DL11_RXFIFO_EN
    logic       ff_full, ff_empty, ff_push, ff_pop;
    logic [7:0] ff_head;

    // Pop before push, so a full FIFO read this cycle still accepts the new byte.
    assign ff_pop  = rd_rbuf & ~ff_empty;
    assign ff_push = rx_push & (~ff_full | ff_pop);
    assign rx_done = ~ff_empty;
    assign rx_byte = ff_head;

    dl11_rxfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rxfifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (ff_push),
        .push_data (rx_push_data),
        .pop       (ff_pop),
        .full      (ff_full),
        .empty     (ff_empty),
        .head      (ff_head)
    );

    always_comb begin
        ovr_d = ovr_q;
        if (rx_push && ff_full && !ff_pop) ovr_d = 1'b1;
        else if (rx_push && ff_full)       ovr_d = ovr_q;
        else if (rd_rbuf)                  ovr_d = 1'b0;
    end
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic       done_q, done_d;
    logic [7:0] rbuf_q, rbuf_d;

    assign rx_done = done_q;
    assign rx_byte = rbuf_q;

    // A read racing an incoming byte returns the old byte and leaves OVR clear.
    always_comb begin
        done_d = done_q;
        rbuf_d = rbuf_q;
        ovr_d  = ovr_q;
        if (rx_push) begin
            rbuf_d = rx_push_data;
            done_d = 1'b1;
            ovr_d  = rd_rbuf ? 1'b0 : (ovr_q | done_q);
        end else if (rd_rbuf) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q <= 1'b0;
            rbuf_q <= '0;
        end else begin
            done_q <= done_d;
            rbuf_q <= rbuf_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            rie_q      <= 1'b0;
            xie_q      <= 1'b0;
            maint_q    <= 1'b0;
            rdy_q      <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            lb_valid_q <= 1'b0;
            lb_data_q  <= '0;
            ovr_q      <= 1'b0;
            rx_irq_q   <= 1'b0;
            tx_irq_q   <= 1'b0;
        end else begin
            ack_q      <= uartreq;
            rdata_q    <= rdata_d;
            if (wr_rcsr) rie_q <= uartwdata[BIT_IE];
            if (wr_xcsr) begin
                xie_q   <= uartwdata[BIT_IE];
                maint_q <= uartwdata[BIT_MAINT];
            end
            rdy_q      <= rdy_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            lb_valid_q <= lb_valid_d;
            lb_data_q  <= lb_data_d;
            ovr_q      <= ovr_d;
            rx_irq_q   <= rx_done & rie_q;
            tx_irq_q   <= rdy_q & xie_q;
        end
    end

    assign uartack   = ack_q;
    assign uartrdata = rdata_q;
    assign tx_valid  = tx_valid_q & ~maint_q;
    assign tx_data   = tx_data_q;
    assign rx_irq    = rx_irq_q;
    assign tx_irq    = tx_irq_q;

endmodule

// File: tb/tb_dl11_uart.sv
// Scoreboard bench for dl11_uart: directed register scenarios then random traffic,
// checked against a queue-based reference model of the DL11 register rules.
module tb_dl11_uart;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        uartreq = 1'b0;
    logic [2:0]  uartaddr = '0;
    logic        uartwr = 1'b0;
    logic [15:0] uartwdata = '0;
    logic        uartack;
    logic [15:0] uartrdata;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_irq;
    logic        tx_irq;

    dl11_uart #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .uartreq   (uartreq),
        .uartaddr  (uartaddr),
        .uartwr    (uartwr),
        .uartwdata (uartwdata),
        .uartack   (uartack),
        .uartrdata (uartrdata),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_irq    (rx_irq),
        .tx_irq    (tx_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
    } rd_exp_t;

    rd_exp_t    rdq[$];
    logic [7:0] txq[$];

    // Reference model state, as visible after the most recent clock edge
    bit         m_done, m_rie, m_ovr, m_rdy, m_xie, m_maint, m_txv, m_lbv, m_rxirq, m_txirq;
    logic [7:0] m_rbuf, m_txd, m_lbd;
    logic [7:0] m_fifo[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp,
                         input logic [15:0] mask);
        n_vec++;
        if (((act ^ exp) & mask) !== 16'h0000) begin
            n_err++;
            $display("FAIL %s: got %o, expected %o (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_done_v();
`ifdef DL11_RXFIFO_EN
        return m_fifo.size() > 0;
`else
        return m_done;
`endif
    endfunction

    task automatic model_reset();
        m_done = 0; m_rie = 0; m_ovr = 0; m_rdy = 1; m_xie = 0; m_maint = 0;
        m_txv = 0; m_lbv = 0; m_rxirq = 0; m_txirq = 0;
        m_rbuf = '0; m_txd = '0; m_lbd = '0;
        m_fifo.delete();
    endtask

    // Monitor: flop handshake events like the DUT does, compare on the falling edge
    logic       req_seen = 1'b0;
    logic       hs_seen = 1'b0;
    logic [7:0] hs_data = '0;

    always @(posedge clk) begin
        req_seen <= uartreq;
        hs_seen  <= tx_valid & tx_ready;
        hs_data  <= tx_data;
    end

    always @(negedge clk) begin
        rd_exp_t    e;
        logic [7:0] b;
        check("uartack_timing", {15'h0, uartack}, {15'h0, req_seen}, 16'hffff);
        if (uartack) begin
            if (rdq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL uartrdata: unexpected ack, data %o", uartrdata);
            end else begin
                e = rdq.pop_front();
                check("uartrdata", uartrdata, e.exp, e.mask);
            end
        end
        if (hs_seen) begin
            if (txq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL tx_byte: unexpected handshake, byte %h", hs_data);
            end else begin
                b = txq.pop_front();
                check("tx_byte", {8'h0, hs_data}, {8'h0, b}, 16'hffff);
            end
        end
    end

    // One clock of stimulus; called on a falling edge, returns on the next one
    task automatic cyc(input bit req, input bit wr, input logic [1:0] ra, input logic [15:0] wd,
                       input bit rxv, input logic [7:0] rxd, input bit txr);
        rd_exp_t    e;
        bit         rd, push, hs, lbv_prev, n_rxirq, n_txirq;
        logic [7:0] pd;
`ifdef DL11_RXFIFO_EN
        bit         full, popped;
`endif
        check("tx_valid", {15'h0, tx_valid}, {15'h0, m_txv & ~m_maint}, 16'hffff);
        if (m_txv && !m_maint) check("tx_data", {8'h0, tx_data}, {8'h0, m_txd}, 16'hffff);
        check("rx_irq", {15'h0, rx_irq}, {15'h0, m_rxirq}, 16'hffff);
        check("tx_irq", {15'h0, tx_irq}, {15'h0, m_txirq}, 16'hffff);

        uartreq   = req;
        uartwr    = wr;
        uartaddr  = {ra, 1'($urandom_range(0, 1))};
        uartwdata = wd;
        rx_valid  = rxv;
        rx_data   = rxd;
        tx_ready  = txr;

        if (req) begin
            e.mask = 16'hffff;
            e.exp  = 16'h0000;
            if (!wr) begin
                case (ra)
                    2'd0: e.exp = {8'h00, m_done_v(), m_rie, 6'h00};
                    2'd1: begin
`ifdef DL11_RXFIFO_EN
                        if (m_fifo.size() == 0) begin
                            e.exp  = {m_ovr, m_ovr, 14'h0};
                            e.mask = 16'hff00;
                        end else begin
                            e.exp = {m_ovr, m_ovr, 6'h00, m_fifo[0]};
                        end
`else
                        e.exp = {m_ovr, m_ovr, 6'h00, m_rbuf};
`endif
                    end
                    2'd2: e.exp = {8'h00, m_rdy, m_xie, 3'h0, m_maint, 2'h0};
                    default: e.exp = 16'h0000;
                endcase
            end
            rdq.push_back(e);
        end

        n_rxirq = m_done_v() & m_rie;
        n_txirq = m_rdy & m_xie;
        rd      = req && !wr && ra == 2'd1;
        push    = m_maint ? m_lbv : rxv;
        pd      = m_maint ? m_lbd : rxd;

`ifdef DL11_RXFIFO_EN
        full   = (m_fifo.size() == DEPTH);
        popped = rd && m_fifo.size() > 0;
        if (push && full && !popped) m_ovr = 1;
        else if (rd && !(push && full)) m_ovr = 0;
        if (popped) void'(m_fifo.pop_front());
        if (push && m_fifo.size() < DEPTH) m_fifo.push_back(pd);
`else
        if (push) begin
            if (rd) m_ovr = 0;
            else if (m_done) m_ovr = 1;
            m_rbuf = pd;
            m_done = 1;
        end else if (rd) begin
            m_done = 0;
            m_ovr  = 0;
        end
`endif

        hs       = m_txv && !m_maint && txr;
        lbv_prev = m_lbv;
        if (hs) begin
            txq.push_back(m_txd);
            m_txv = 0;
            m_rdy = 1;
        end
        if (lbv_prev) m_rdy = 1;
        m_lbv = 0;
        if (req && wr && ra == 2'd3) begin
            m_txd = wd[7:0];
            m_rdy = 0;
            if (m_maint) begin
                m_lbv = 1;
                m_lbd = wd[7:0];
            end else begin
                m_txv = 1;
            end
        end
        if (req && wr && ra == 2'd0) m_rie = wd[6];
        if (req && wr && ra == 2'd2) begin
            m_xie   = wd[6];
            m_maint = wd[2];
        end
        m_rxirq = n_rxirq;
        m_txirq = n_txirq;

        @(negedge clk);
        uartreq  = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit txr);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 16'h0, 0, 8'h0, txr);
    endtask

    task automatic bus_rd(input logic [1:0] ra);
        cyc(1, 0, ra, 16'h0, 0, 8'h0, 0);
        idle(1, 0);
    endtask

    task automatic bus_wr(input logic [1:0] ra, input logic [15:0] wd);
        cyc(1, 1, ra, wd, 0, 8'h0, 0);
        idle(1, 0);
    endtask

    bit          prev_req, r_req, r_wr, r_rxv, r_txr;
    logic [1:0]  r_ra;
    logic [15:0] r_wd;
    logic [7:0]  r_rxd;

    initial begin
        model_reset();
        #1 rstn = 1'b0;
        @(negedge clk);
        check("reset_uartrdata", uartrdata, 16'h0, 16'hffff);
        check("reset_tx_data", {8'h0, tx_data}, 16'h0, 16'hffff);
        @(negedge clk);
        rstn = 1'b1;

        // Reset state of the CSRs
        bus_rd(2'd0);
        bus_rd(2'd2);

        // Single received byte, then a read clears DONE
        cyc(0, 0, 2'd0, 16'h0, 1, 8'h41, 0);
        idle(1, 0);
        bus_rd(2'd0);
        bus_rd(2'd1);
        bus_rd(2'd0);

        // Two bytes without a read: overrun or FIFO queueing
        cyc(0, 0, 2'd0, 16'h0, 1, 8'h31, 0);
        cyc(0, 0, 2'd0, 16'h0, 1, 8'h32, 0);
        idle(1, 0);
        bus_rd(2'd1);
        bus_rd(2'd1);
        bus_rd(2'd0);

        // Transmit held off by the serializer, then accepted
        bus_wr(2'd3, 16'o000123);
        idle(2, 0);
        bus_rd(2'd2);
        idle(1, 1);
        bus_rd(2'd2);

        // Interrupt enables
        bus_wr(2'd2, 16'o000100);
        idle(2, 0);
        bus_wr(2'd0, 16'o000100);
        cyc(0, 0, 2'd0, 16'h0, 1, 8'h55, 0);
        idle(2, 0);
        bus_rd(2'd1);
        idle(2, 0);

        // Maintenance loopback
        bus_wr(2'd2, 16'o000004);
        bus_wr(2'd3, 16'o000132);
        idle(1, 0);
        bus_rd(2'd1);
        bus_rd(2'd2);
        bus_wr(2'd2, 16'o000000);

        // Simultaneous RBUF read and incoming byte
        cyc(0, 0, 2'd0, 16'h0, 1, 8'h11, 0);
        idle(1, 0);
        cyc(1, 0, 2'd1, 16'h0, 1, 8'h22, 0);
        idle(1, 0);
        bus_rd(2'd1);

        // Reset asserted while a byte is pending to the serializer
        bus_wr(2'd3, 16'h0077);
        idle(2, 0);
        rstn = 1'b0;
        #1;
        check("rst_mid_tx_valid", {15'h0, tx_valid}, 16'h0, 16'hffff);
        check("rst_mid_tx_irq", {15'h0, tx_irq}, 16'h0, 16'hffff);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        bus_rd(2'd2);

        // Random traffic
        prev_req = 0;
        for (int i = 0; i < 4000; i++) begin
            r_req = !prev_req && ($urandom_range(0, 2) == 0);
            r_wr  = 1'($urandom_range(0, 1));
            r_ra  = 2'($urandom_range(0, 3));
            r_wd  = 16'($urandom);
            if (r_wr && r_ra == 2'd2) r_wd[2] = ($urandom_range(0, 3) == 0);
            r_rxv = ($urandom_range(0, 3) == 0);
            r_rxd = 8'($urandom);
            r_txr = 1'($urandom_range(0, 1));
            cyc(r_req, r_wr, r_ra, r_wd, r_rxv, r_rxd, r_txr);
            prev_req = r_req;
        end
        idle(4, 0);

        check("rdq_drained", 16'(rdq.size()), 16'h0, 16'hffff);
        check("txq_drained", 16'(txq.size()), 16'h0, 16'hffff);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
